field_adder_tree_pipe: RTL



---
 rtl/field_adder_tree_pipe.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/field_adder_tree_pipe.sv
// Pipelined GF(2^61-1) adder tree with a trailing batch accumulator.
// Ports:
//   clk        rising-edge clock
//   rstb       asynchronous active-low reset
//   in_valid   v_parts is valid this cycle (accepted unconditionally)
//   v_parts    ngates input field elements
//   clr        synchronous abort of in-flight vectors and partial batch
//   v          canonical field sum of one batch
//   out_valid  one-cycle strobe, v is new
//   batch_idx  vectors already folded into the current accumulation
module field_adder_tree_pipe #(
    parameter int unsigned ngates = 8,
    parameter int unsigned nbatch = 1,
    localparam int unsigned cntbits = (nbatch > 1) ? $clog2(nbatch) : 1
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               in_valid,
    input  logic [60:0]        v_parts [ngates],
    input  logic               clr,
    output logic [60:0]        v,
    output logic               out_valid,
    output logic [cntbits-1:0] batch_idx
);

    localparam int unsigned nlevels = $clog2(ngates);
    localparam logic [60:0] prime = {61{1'b1}};

    // Entry count of tree level k; level -1 is the input vector.
    function automatic int unsigned lvl_cnt(input int k);
        int unsigned n;
        n = ngates;
        for (int j = 0; j <= k; j++) n = (n + 1) / 2;
        return n;
    endfunction

    // Offset of level k inside the flat node array.
    function automatic int unsigned lvl_off(input int k);
        int unsigned o;
        o = 0;
        for (int j = 0; j < k; j++) o += lvl_cnt(j);
        return o;
    endfunction

    localparam int unsigned nodes = lvl_off(int'(nlevels));

    // Modular add; operands are already < p, so one end-around carry suffices.
    function automatic logic [60:0] fadd(input logic [60:0] a, input logic [60:0] b);
        logic [61:0] s;
        logic [60:0] r;
        s = {1'b0, a} + {1'b0, b};
        r = s[60:0] + 61'(s[61]);
        return (r == prime) ? '0 : r;
    endfunction

    // Map the redundant all-ones encoding of zero onto 0.
    logic [60:0] canon [ngates];
    always_comb begin
        for (int i = 0; i < int'(ngates); i++)
            canon[i] = (v_parts[i] == prime) ? '0 : v_parts[i];
    end

    logic [nlevels-1:0] vld;
    logic [60:0]        node [nodes];

    // Valid bits shift alongside the data; clr empties the pipe.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            vld <= '0;
        end else begin
            for (int k = int'(nlevels) - 1; k > 0; k--) vld[k] <= vld[k-1] & ~clr;
            vld[0] <= in_valid & ~clr;
        end
    end

    for (genvar k = 0; k < int'(nlevels); k++) begin : g_lvl
        localparam int unsigned nin  = lvl_cnt(k - 1);
        localparam int unsigned nout = lvl_cnt(k);
        localparam int unsigned off  = lvl_off(k);
        logic en;

        if (k == 0) begin : g_en0
            assign en = in_valid;
        end else begin : g_enk
            assign en = vld[k-1];
        end

        for (genvar i = 0; i < int'(nout); i++) begin : g_cell
            logic [60:0] lo;
            if (k == 0) begin : g_lo0
                assign lo = canon[2*i];
            end else begin : g_lok
                assign lo = node[lvl_off(k - 1) + 2*i];
            end

            if (2*i + 1 < int'(nin)) begin : g_add
                logic [60:0] hi;
                if (k == 0) begin : g_hi0
                    assign hi = canon[2*i+1];
                end else begin : g_hik
                    assign hi = node[lvl_off(k - 1) + 2*i + 1];
                end
                always_ff @(posedge clk or negedge rstb) begin
                    if (!rstb)   node[off+i] <= '0;
                    else if (en) node[off+i] <= fadd(lo, hi);
                end
            end else begin : g_pass
                // Odd leftover entry is only delayed to stay level-aligned.
                always_ff @(posedge clk or negedge rstb) begin
                    if (!rstb)   node[off+i] <= '0;
                    else if (en) node[off+i] <= lo;
                end
            end
        end
    end

    logic [60:0] tree;
    logic        tree_vld;
    assign tree     = node[nodes-1];
    assign tree_vld = vld[nlevels-1];

    typedef enum logic {IDLE, ACC} state_t;

    state_t             state_q, state_d;
    logic [cntbits-1:0] cnt_q, cnt_d;
    logic [60:0]        acc_q, acc_d;
    logic [60:0]        v_d;
    logic               ov_d;
    logic               last;
    logic [60:0]        sum;

    assign last = (cnt_q == cntbits'(nbatch - 1));
    assign sum  = (state_q == IDLE) ? tree : fadd(acc_q, tree);

    // State and accumulator registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            v         <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            v         <= v_d;
            out_valid <= ov_d;
        end
    end

    // Next state: clr wins over an arriving tree result.
    always_comb begin
        state_d = state_q;
        if (clr)           state_d = IDLE;
        else if (tree_vld) state_d = last ? IDLE : ACC;
    end

    // Accumulator datapath and output strobe.
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        v_d   = v;
        ov_d  = 1'b0;
        if (clr) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (tree_vld) begin
            if (last) begin
                v_d   = sum;
                ov_d  = 1'b1;
                cnt_d = '0;
                acc_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + cntbits'(1);
            end
        end
    end

    assign batch_idx = cnt_q;

endmodule
